int_alu_exec_stage: RTL and testbench
=====================================

Name: int_alu_exec_stage

Overview:
Execute stage of the integer pipeline. It accepts one decoded ALU operation per handshake, computes ADD/SUB/SLT/SLTU/logic results in one cycle and shifts iteratively, then holds the result in an output register until the writeback stage consumes it. It sits between the issue/operand-read stage (upstream) and writeback (downstream). Set-less-than compare results are zero-extended to N bits.

Parameters:
N, 32, operand/result width (>=4, power of 2)
TAG_W, 5, destination-register tag width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream operation valid
in_ready  output  1  stage can accept operation this cycle
in_op  input  4  alu_op_t opcode
in_a  input  N  operand A
in_b  input  N  operand B (shift amount = in_b[$clog2(N)-1:0])
in_tag  input  TAG_W  destination tag, passed through
out_valid  output  1  result register valid
out_ready  input  1  writeback accepts result
out_result  output  N  computed result
out_tag  output  TAG_W  tag of out_result
out_illegal  output  1  opcode was unassigned (result forced 0)

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_result=0, out_tag=0, out_illegal=0, shift counter=0.
- Opcodes: ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SRA=9. Codes 10-15 are illegal: result=0, out_illegal=1, latency 1.
- ADD/SUB wrap modulo 2^N. SLT: signed A<B gives 1, else 0. SLTU: unsigned A<B gives 1, else 0. Both produce {N-1 zeros, bit}.
- Accept = in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Full throughput for single-cycle ops under continuous out_ready.
- FSM states:
  - IDLE: on accept of a non-shift op, or a shift with shamt=0, load out_result/out_tag/out_illegal and set out_valid=1 next cycle (latency 1). On accept of a shift with shamt=k>0, latch operand/tag/op, set counter=k, go to SHIFT.
  - SHIFT: each cycle shift the working register 1 bit (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate MSB) and decrement the counter. When the counter reaches 1, write the final value to out_result, set out_valid=1, go to IDLE. Total latency is k+1 cycles from accept. in_ready=0 throughout.
- out_valid && out_ready clears out_valid unless a new accept loads in the same cycle (then out_valid stays 1 with the new data).
- out_valid && !out_ready: out_result/out_tag/out_illegal held stable, in_ready=0.
- A shift finishing in SHIFT while the previous result is still unconsumed cannot occur: entry to SHIFT requires an empty or draining output register.
- Reset mid-SHIFT aborts the operation and discards it; nothing is emitted.
- Inputs are ignored when !in_valid or !in_ready.

Optional Feature:
ALU_BARREL_SHIFT_EN: when defined, SLL/SRL/SRA use a combinational barrel shifter. All ops then have latency 1, the SHIFT state and counter are not synthesised, and in_ready = !out_valid || out_ready. When undefined, the iterative shifter described above is used. Results are identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg: alu_op_t enum (4-bit, values above), ALU_OP_W=4, state enum exec_state_t {IDLE, SHIFT}, function is_shift_op(alu_op_t).
- Sub-module: int_serial_shifter (operand, shamt, op, start, busy/done, result), instantiated only when ALU_BARREL_SHIFT_EN is undefined. The adder/comparator datapath stays inline.

Test Plan:
- SLT with a=0xFFFFFFFF, b=0x00000001 -> out_result=0x00000001 one cycle after accept. SLTU with the same operands -> 0x00000000.
- 8 back-to-back ADDs (a=i, b=1, tag=i) with out_ready=1 -> out_valid high 8 consecutive cycles, results 1..8, tags 0..7 in order.
- ADD accepted, out_ready=0 for 3 cycles -> in_ready=0, out_result stable. out_ready=1 -> consumed, and an in-flight accept that cycle appears next cycle.
- SRA a=0x80000000, shamt=4 -> out_result=0xF8000000 exactly 5 cycles after accept (1 cycle with ALU_BARREL_SHIFT_EN). in_ready=0 during SHIFT. SLL shamt=0 -> latency 1.
- Opcode 12 -> out_illegal=1, out_result=0. The next legal op clears out_illegal.
- Assert rst during SHIFT (SLL shamt=20, cycle 6) -> out_valid=0 immediately. After rst drops, in_ready=1, no stale result emitted.

Source files
------------

// File: rtl/int_alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the integer ALU execute stage: opcode encoding,
// execute-FSM state type and the shift-opcode helper.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    // Codes 10..15 are unassigned and flagged illegal by the execute stage.
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
    endfunction

endpackage

// File: rtl/int_alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// int_alu_exec_stage_if
// Issue-side and writeback-side handshake bundle of the execute stage.
//   master : upstream/downstream environment (drives operation, out_ready)
//   slave  : execute stage (drives in_ready and the result register)
// Signals: in_valid/in_ready/in_op/in_a/in_b/in_tag,
//          out_valid/out_ready/out_result/out_tag/out_illegal
// -----------------------------------------------------------------------------
interface int_alu_exec_stage_if
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 5
) ();

    logic                in_valid;
    logic                in_ready;
    logic [ALU_OP_W-1:0] in_op;
    logic [N-1:0]        in_a;
    logic [N-1:0]        in_b;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_result;
    logic [TAG_W-1:0]    out_tag;
    logic                out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );

endinterface

// File: rtl/int_alu_exec_stage_shifter.sv
// -----------------------------------------------------------------------------
// int_serial_shifter
// One-bit-per-cycle shifter for SLL/SRL/SRA.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_start     : load operand/shamt/op (shamt must be non-zero)
//   i_operand   : value to shift
//   i_shamt     : shift amount
//   i_op        : ALU_SLL / ALU_SRL / ALU_SRA
//   o_busy      : a shift is in progress
//   o_done      : final step this cycle; o_result is the finished value
//   o_result    : working register shifted by one more bit
// -----------------------------------------------------------------------------
module int_serial_shifter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [N-1:0]         i_operand,
    input  logic [$clog2(N)-1:0] i_shamt,
    input  alu_op_t              i_op,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [N-1:0]         o_result
);
    localparam int SH_W = $clog2(N);

    logic [N-1:0]    r_work;
    logic [SH_W-1:0] r_count;
    alu_op_t         r_op;

    assign o_busy = (r_count != '0);
    // The owner captures o_result on the step where one bit remains.
    assign o_done = (r_count == SH_W'(1));

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        o_result = r_work;
        case (r_op)
            ALU_SLL: o_result = {r_work[N-2:0], 1'b0};
            ALU_SRL: o_result = {1'b0, r_work[N-1:1]};
            ALU_SRA: o_result = {r_work[N-1], r_work[N-1:1]};
            default: o_result = r_work;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_count <= '0;
            r_op    <= ALU_ADD;
        end else if (i_start) begin
            r_work  <= i_operand;
            r_count <= i_shamt;
            r_op    <= i_op;
        end else if (o_busy) begin
            r_work  <= o_result;
            r_count <= r_count - SH_W'(1);
        end
    end

endmodule

// File: rtl/int_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// int_alu_exec_stage
// Integer execute stage: ADD/SUB/SLT/SLTU/AND/OR/XOR in one cycle, shifts
// either iteratively (default) or through a barrel shifter, result held in
// an output register until writeback takes it.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : int_alu_exec_stage_if.slave (issue + writeback handshakes)
// Build option:
//   ALU_BARREL_SHIFT_EN : single-cycle barrel shifts, no SHIFT state.
// -----------------------------------------------------------------------------
module int_alu_exec_stage
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    int_alu_exec_stage_if.slave bus
);
    localparam int SH_W = $clog2(N);

    alu_op_t          w_op;
    logic [SH_W-1:0]  w_shamt;
    logic             w_accept;
    logic [N-1:0]     w_alu_result;
    logic             w_illegal;

    logic             r_out_valid;
    logic [N-1:0]     r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_illegal;

    assign w_op     = alu_op_t'(bus.in_op);
    assign w_shamt  = bus.in_b[SH_W-1:0];
    assign w_accept = bus.in_valid && bus.in_ready;

    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_tag     = r_out_tag;
    assign bus.out_illegal = r_out_illegal;

    always_comb begin
        w_alu_result = '0;
        w_illegal    = 1'b0;
        case (w_op)
            ALU_ADD:  w_alu_result = bus.in_a + bus.in_b;
            ALU_SUB:  w_alu_result = bus.in_a - bus.in_b;
            ALU_SLT:  w_alu_result = {{(N-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            ALU_SLTU: w_alu_result = {{(N-1){1'b0}}, (bus.in_a < bus.in_b)};
            ALU_AND:  w_alu_result = bus.in_a & bus.in_b;
            ALU_OR:   w_alu_result = bus.in_a | bus.in_b;
            ALU_XOR:  w_alu_result = bus.in_a ^ bus.in_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  w_alu_result = bus.in_a << w_shamt;
            ALU_SRL:  w_alu_result = bus.in_a >> w_shamt;
            ALU_SRA:  w_alu_result = $unsigned($signed(bus.in_a) >>> w_shamt);
`else
            // Only shamt==0 shifts complete here; the rest go to the shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: w_alu_result = bus.in_a;
`endif
            default:  w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    assign bus.in_ready = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_alu_result;
            r_out_tag     <= bus.in_tag;
            r_out_illegal <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

`else

    exec_state_t      r_state;
    logic [TAG_W-1:0] r_shift_tag;
    logic             w_start_shift;
    logic             w_shift_busy;
    logic             w_shift_done;
    logic [N-1:0]     w_shift_result;

    assign w_start_shift = w_accept && is_shift_op(w_op) && (w_shamt != '0);
    assign bus.in_ready  = (r_state == IDLE) && !w_shift_busy
                           && (!r_out_valid || bus.out_ready);

    int_serial_shifter #(.N(N)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start_shift),
        .i_operand (bus.in_a),
        .i_shamt   (w_shamt),
        .i_op      (w_op),
        .o_busy    (w_shift_busy),
        .o_done    (w_shift_done),
        .o_result  (w_shift_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shift_tag   <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            // A later load in this block overrides the drain.
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start_shift) begin
                        r_shift_tag <= bus.in_tag;
                        r_state     <= SHIFT;
                    end else if (w_accept) begin
                        r_out_valid   <= 1'b1;
                        r_out_result  <= w_alu_result;
                        r_out_tag     <= bus.in_tag;
                        r_out_illegal <= w_illegal;
                    end
                end
                SHIFT: begin
                    // Output register is guaranteed empty: entry required it.
                    if (w_shift_done) begin
                        r_out_valid   <= 1'b1;
                        r_out_result  <= w_shift_result;
                        r_out_tag     <= r_shift_tag;
                        r_out_illegal <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_int_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_int_alu_exec_stage
// Self-checking bench for int_alu_exec_stage. Expected results and their
// arrival cycle are queued at accept time and compared when the stage
// presents/hands off its result. Honours ALU_BARREL_SHIFT_EN for latency.
// -----------------------------------------------------------------------------
module tb_int_alu_exec_stage;
    import alu_pkg::*;

    localparam int N     = 32;
    localparam int TAG_W = 5;
    localparam int SH_W  = $clog2(N);
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]     res;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               vis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    bit   head_seen = 1'b0;
    bit   rand_done = 1'b0;
    exp_t sb[$];

    int_alu_exec_stage_if #(.N(N), .TAG_W(TAG_W)) bus ();

    int_alu_exec_stage #(.N(N), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [SH_W-1:0] sh = b[SH_W-1:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
            4'd3:    return (a < b) ? N'(1) : N'(0);
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return $unsigned($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    function automatic int lat(input logic [3:0] op, input logic [N-1:0] b);
        int sh = int'(b[SH_W-1:0]);
        if (!BARREL && op >= 4'd7 && op <= 4'd9 && sh != 0) return sh + 1;
        return 1;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [N-1:0] exp_res,
                        input bit track);
        int   waited = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", bus.in_ready, 1'b1);
        if (bus.in_ready && track) begin
            e.res = exp_res;
            e.tag = tag;
            e.ill = (op > 4'd9);
            e.vis = cyc + lat(op, b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [3:0] op, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic [TAG_W-1:0] tag);
        send(op, a, b, tag, model(op, a, b), 1'b1);
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: arrival cycle on first sight, data on handoff.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            check("sb_nonempty", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                if (!head_seen) begin
                    check("latency", cyc, sb[0].vis);
                    head_seen = 1'b1;
                end
                if (bus.out_ready) begin
                    check("result", bus.out_result, sb[0].res);
                    check("tag", bus.out_tag, sb[0].tag);
                    check("illegal", bus.out_illegal, sb[0].ill);
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   dir_op[6];
        logic [N-1:0] dir_a[6];
        logic [N-1:0] dir_b[6];

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_result", bus.out_result, '0);
        check("rst_out_tag", bus.out_tag, '0);
        check("rst_out_illegal", bus.out_illegal, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Signed vs unsigned compare
        send(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1, 32'h0000_0001, 1'b1);
        send(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2, 32'h0000_0000, 1'b1);
        drain();

        // Back-to-back ADDs at full throughput
        for (int i = 0; i < 8; i++) begin
            send(4'd0, N'(i), N'(1), TAG_W'(i), N'(i + 1), 1'b1);
        end
        drain();

        // Output stall, then handoff with a waiting operation
        bus.out_ready = 1'b0;
        send(4'd0, 32'd10, 32'd20, 5'd3, 32'd30, 1'b1);
        fork
            send(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 32'h0FF0_0FF0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 1'b0);
                    check("stall_valid", bus.out_valid, 1'b1);
                    check("stall_result", bus.out_result, 32'd30);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Iterative SRA, then zero-amount SLL
        send(4'd9, 32'h8000_0000, 32'd4, 5'd9, 32'hF800_0000, 1'b1);
        @(negedge clk);
        check("shift_in_ready", bus.in_ready, BARREL);
        drain();
        send(4'd7, 32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678, 1'b1);
        drain();

        // Illegal opcode, then a legal op clears the flag
        send(4'd12, 32'hDEAD_BEEF, 32'h1, 5'd12, 32'h0, 1'b1);
        drain();
        send(4'd0, 32'd5, 32'd7, 5'd13, 32'd12, 1'b1);
        drain();

        // Directed corner values through the model
        dir_op = '{4'd1, 4'd4, 4'd5, 4'd8, 4'd7, 4'd9};
        dir_a  = '{32'h0, 32'hFFFF_0000, 32'h0000_00F0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
        dir_b  = '{32'h1, 32'h0F0F_0F0F, 32'h0000_000F, 32'd31, 32'd31, 32'd3};
        for (int i = 0; i < 6; i++) begin
            send_model(dir_op[i], dir_a[i], dir_b[i], TAG_W'(i + 16));
        end
        drain();

        // Random ops under random writeback backpressure
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send_model(4'($urandom_range(0, 15)), $urandom, N'($urandom),
                               TAG_W'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset during a long shift: nothing may emerge afterwards
        send(4'd3, 32'd1, 32'd2, 5'd14, 32'd1, 1'b1);
        drain();
        send(4'd7, 32'd1, 32'd20, 5'd4, 32'h0010_0000, BARREL);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_out_result", bus.out_result, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        repeat (25) begin
            @(negedge clk);
            check("no_stale_result", bus.out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
